// File: rtl/mmio_map_gen.sv
`default_nettype none
// ============================================================================
// Module   : mmio_map_gen
// Purpose  : Memory-mapped I/O decoder for the CPU data-memory port.
//            Addresses with the top bit clear go to RAM; addresses with the
//            top bit set select an eight-register I/O window:
//              0 BTN_LIVE  synchronised button levels (R)
//              1 BTN_EDGE  sticky rising-edge bits, clear-on-read (R)
//              2 CMD_LO    SD_cmd[31:0] (RW)
//              3 CMD_HI    SD_cmd[CMD_W-1:32], bit31 = start / pending (RW)
//              4 UART      write: address strobe, read: last byte
//              5 RESP      SD response FIFO head, pop-on-read (R)
//              6 STATUS    {busy_any, overflow, err_start, 21'b0, count}
//              7 reserved
// Ports    : clk, reset (sync, active-high)
//            CPU side : addr, dataIn, dataOut, writeEnable, readEnable
//            RAM side : RAM_out, RAM_write
//            Buttons  : BTN (asynchronous)
//            SD side  : SD_responseByte, SD_response, SD_busy, SD_cmd,
//                       SD_start
//            UART side: UART_setAddr, UART_addr, UART_lastByte
// Revision : 1.0 - initial release
// ============================================================================
module mmio_map_gen #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int BTN_W      = 5,
    parameter int CMD_W      = 48,
    parameter int RESP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    input  logic              writeEnable,
    input  logic              readEnable,
    input  logic [DATA_W-1:0] RAM_out,
    output logic              RAM_write,
    input  logic [BTN_W-1:0]  BTN,
    input  logic              SD_responseByte,
    input  logic [7:0]        SD_response,
    input  logic              SD_busy,
    output logic [CMD_W-1:0]  SD_cmd,
    output logic              SD_start,
    output logic              UART_setAddr,
    output logic [11:0]       UART_addr,
    input  logic [7:0]        UART_lastByte
);

    localparam int c_PTR_W = $clog2(RESP_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_HI_W  = CMD_W - 32;

    localparam logic [2:0] c_OFF_BTN_LIVE = 3'd0;
    localparam logic [2:0] c_OFF_BTN_EDGE = 3'd1;
    localparam logic [2:0] c_OFF_CMD_LO   = 3'd2;
    localparam logic [2:0] c_OFF_CMD_HI   = 3'd3;
    localparam logic [2:0] c_OFF_UART     = 3'd4;
    localparam logic [2:0] c_OFF_RESP     = 3'd5;
    localparam logic [2:0] c_OFF_STATUS   = 3'd6;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(RESP_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [BTN_W-1:0]   r_sync1;
    logic [BTN_W-1:0]   r_sync2;
    logic [BTN_W-1:0]   r_sync3;
    logic [BTN_W-1:0]   r_edge_bits;
    logic [CMD_W-1:0]   r_cmd;
    logic               r_pending;
    logic               r_err_start;
    logic               r_overflow;
    logic               r_uart_set;
    logic [11:0]        r_uart_addr;
    logic [7:0]         r_mem [RESP_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic             w_io;
    logic [2:0]       w_off;
    logic             w_io_wr;
    logic             w_io_rd;
    logic             w_busy_any;
    logic             w_wr_lo;
    logic             w_wr_hi;
    logic             w_start_req;
    logic             w_start_ok;
    logic             w_start_err;
    logic             w_fire;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_wr_status;
    logic             w_rd_edge;
    logic [BTN_W-1:0] w_btn_edge;
    logic [7:0]       w_head;
    logic [31:0]      w_rdata;

    assign w_io    = addr[ADDR_W-1];
    assign w_off   = addr[2:0];
    assign w_io_wr = writeEnable & w_io;
    assign w_io_rd = readEnable & w_io;

    assign w_busy_any  = r_pending | SD_busy;
    assign w_wr_lo     = w_io_wr & (w_off == c_OFF_CMD_LO) & ~w_busy_any;
    assign w_wr_hi     = w_io_wr & (w_off == c_OFF_CMD_HI) & ~w_busy_any;
    assign w_start_req = w_io_wr & (w_off == c_OFF_CMD_HI) & dataIn[31];
    assign w_start_ok  = w_start_req & ~w_busy_any;
    assign w_start_err = w_start_req & w_busy_any;

    // The start pulse is issued in the cycle the controller is free while a
    // start is pending; pending retires at the closing edge of that cycle.
    // Gating with reset keeps a reset cycle from emitting a stray pulse.
    assign w_fire = r_pending & ~SD_busy;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_pop   = w_io_rd & (w_off == c_OFF_RESP) & ~w_empty;
    // A full FIFO still accepts a byte when a pop frees a slot this cycle.
    assign w_push  = SD_responseByte & (~w_full | w_pop);
    assign w_drop  = SD_responseByte & ~w_push;

    assign w_wr_status = w_io_wr & (w_off == c_OFF_STATUS);
    assign w_rd_edge   = w_io_rd & (w_off == c_OFF_BTN_EDGE);
    assign w_btn_edge  = r_sync2 & ~r_sync3;
    assign w_head      = w_empty ? 8'hFF : r_mem[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_OFF_BTN_LIVE: w_rdata[BTN_W-1:0] = r_sync2;
            c_OFF_BTN_EDGE: w_rdata[BTN_W-1:0] = r_edge_bits;
            c_OFF_CMD_LO:   w_rdata = r_cmd[31:0];
            c_OFF_CMD_HI: begin
                w_rdata[c_HI_W-1:0] = r_cmd[CMD_W-1:32];
                w_rdata[31]         = r_pending;
            end
            c_OFF_UART:     w_rdata[7:0] = UART_lastByte;
            c_OFF_RESP: begin
                w_rdata[7:0] = w_head;
                w_rdata[31]  = ~w_empty;
            end
            c_OFF_STATUS: begin
                w_rdata[c_CNT_W-1:0] = r_count;
                w_rdata[31]          = w_busy_any;
                w_rdata[30]          = r_overflow;
                w_rdata[29]          = r_err_start;
            end
            default:        w_rdata = '0;
        endcase
    end

    assign dataOut      = w_io ? w_rdata : RAM_out;
    assign RAM_write    = writeEnable & ~w_io;
    assign SD_cmd       = r_cmd;
    assign SD_start     = w_fire & ~reset;
    assign UART_setAddr = r_uart_set;
    assign UART_addr    = r_uart_addr;

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sync3     <= '0;
            r_edge_bits <= '0;
            r_cmd       <= '0;
            r_pending   <= 1'b0;
            r_err_start <= 1'b0;
            r_overflow  <= 1'b0;
            r_uart_set  <= 1'b0;
            r_uart_addr <= '0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            // Clear-on-read removes exactly the bits that were returned; the
            // returned value is the whole register, so only new edges survive.
            if (w_rd_edge) begin
                r_edge_bits <= w_btn_edge;
            end else begin
                r_edge_bits <= r_edge_bits | w_btn_edge;
            end

            if (w_wr_lo) begin
                r_cmd[31:0] <= dataIn[31:0];
            end
            if (w_wr_hi) begin
                r_cmd[CMD_W-1:32] <= dataIn[c_HI_W-1:0];
            end

            // busy_any includes pending, so set and retire never coincide.
            if (w_start_ok) begin
                r_pending <= 1'b1;
            end else if (w_fire) begin
                r_pending <= 1'b0;
            end

            if (w_start_err) begin
                r_err_start <= 1'b1;
            end else if (w_wr_status && dataIn[29]) begin
                r_err_start <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status && dataIn[30]) begin
                r_overflow <= 1'b0;
            end

            r_uart_set <= w_io_wr & (w_off == c_OFF_UART);
            // Address is captured with the write so it stays stable while the
            // strobe is high, independent of what the CPU drives next.
            if (w_io_wr && (w_off == c_OFF_UART)) begin
                r_uart_addr <= dataIn[11:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // SD response FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= SD_response;
        end
    end

    // Middle address bits are don't-care inside the I/O window.
    logic w_unused;
    assign w_unused = &{1'b0, addr[ADDR_W-2:3]};

endmodule
`default_nettype wire

// File: tb/tb_mmio_map_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_map_gen
// Purpose  : Self-checking bench for mmio_map_gen with default parameters.
//            Expected FIFO read words are queued when bytes are pushed and
//            popped when the RESP register is read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_map_gen;

    logic        clk;
    logic        reset;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        writeEnable;
    logic        readEnable;
    logic [31:0] RAM_out;
    logic        RAM_write;
    logic [4:0]  BTN;
    logic        SD_responseByte;
    logic [7:0]  SD_response;
    logic        SD_busy;
    logic [47:0] SD_cmd;
    logic        SD_start;
    logic        UART_setAddr;
    logic [11:0] UART_addr;
    logic [7:0]  UART_lastByte;

    int n_cmp;
    int n_mis;
    logic [31:0] sb_q[$];

    mmio_map_gen dut (
        .clk             (clk),
        .reset           (reset),
        .addr            (addr),
        .dataIn          (dataIn),
        .dataOut         (dataOut),
        .writeEnable     (writeEnable),
        .readEnable      (readEnable),
        .RAM_out         (RAM_out),
        .RAM_write       (RAM_write),
        .BTN             (BTN),
        .SD_responseByte (SD_responseByte),
        .SD_response     (SD_response),
        .SD_busy         (SD_busy),
        .SD_cmd          (SD_cmd),
        .SD_start        (SD_start),
        .UART_setAddr    (UART_setAddr),
        .UART_addr       (UART_addr),
        .UART_lastByte   (UART_lastByte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr        = a;
        dataIn      = d;
        writeEnable = 1'b1;
        step();
        writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        addr       = a;
        readEnable = 1'b1;
        #1;
        v = dataOut;
        step();
        readEnable = 1'b0;
    endtask

    task automatic peek(input logic [11:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dataOut;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        n_cmp++; if (SD_cmd !== 48'h0) begin n_mis++; $display("FAIL reset_sd_cmd: got %h expected %h", SD_cmd, 48'h0); end
        n_cmp++; if (SD_start !== 1'b0) begin n_mis++; $display("FAIL reset_sd_start: got %b expected 0", SD_start); end
        n_cmp++; if (UART_setAddr !== 1'b0) begin n_mis++; $display("FAIL reset_uart_set: got %b expected 0", UART_setAddr); end
        peek(12'h806, v);
        n_cmp++; if (v !== 32'h0) begin n_mis++; $display("FAIL reset_status: got %h expected %h", v, 32'h0); end
        peek(12'h805, v);
        n_cmp++; if (v !== 32'h0000_00FF) begin n_mis++; $display("FAIL reset_resp_empty: got %h expected %h", v, 32'hFF); end
        peek(12'h801, v);
        n_cmp++; if (v !== 32'h0) begin n_mis++; $display("FAIL reset_btn_edge: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_ram();
        logic [31:0] v;
        addr = 12'h000; dataIn = 32'h0000_0800; writeEnable = 1'b1; #1;
        n_cmp++; if (RAM_write !== 1'b1) begin n_mis++; $display("FAIL ram_write_low: got %b expected 1", RAM_write); end
        addr = 12'h800; #1;
        n_cmp++; if (RAM_write !== 1'b0) begin n_mis++; $display("FAIL ram_write_io: got %b expected 0", RAM_write); end
        writeEnable = 1'b0;
        RAM_out = 32'h1234_5678;
        peek(12'h000, v);
        n_cmp++; if (v !== 32'h1234_5678) begin n_mis++; $display("FAIL ram_passthru: got %h expected %h", v, 32'h1234_5678); end
        peek(12'h807, v);
        n_cmp++; if (v !== 32'h0) begin n_mis++; $display("FAIL reserved_read: got %h expected 0", v); end
        step();
    endtask

    task automatic test_sd_start();
        int pulses;
        int first;
        SD_busy = 1'b0;
        wr(12'h802, 32'hDEAD_BEEF);
        wr(12'h803, 32'h8000_1234);
        n_cmp++; if (SD_cmd !== 48'h1234_DEAD_BEEF) begin n_mis++; $display("FAIL sd_cmd_value: got %h expected %h", SD_cmd, 48'h1234_DEAD_BEEF); end
        pulses = 0; first = -1;
        for (int i = 0; i < 5; i++) begin
            if (SD_start === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            step();
        end
        n_cmp++; if (pulses !== 1) begin n_mis++; $display("FAIL sd_start_count: got %0d expected 1", pulses); end
        n_cmp++; if (first !== 0) begin n_mis++; $display("FAIL sd_start_latency: got %0d expected 0", first); end
    endtask

    task automatic test_busy();
        logic [31:0] v;
        int early;
        early = 0;
        wr(12'h802, 32'hCAFE_F00D);
        addr = 12'h803; dataIn = 32'h8000_00AB; writeEnable = 1'b1;
        step();
        writeEnable = 1'b0;
        SD_busy = 1'b1;
        #1; if (SD_start === 1'b1) early++;
        wr(12'h803, 32'h8000_00CD);
        if (SD_start === 1'b1) early++;
        wr(12'h802, 32'h0000_0000);
        if (SD_start === 1'b1) early++;
        n_cmp++; if (SD_cmd !== 48'h00AB_CAFE_F00D) begin n_mis++; $display("FAIL busy_cmd_hold: got %h expected %h", SD_cmd, 48'h00AB_CAFE_F00D); end
        rd(12'h806, v);
        if (SD_start === 1'b1) early++;
        n_cmp++; if (v !== 32'hA000_0000) begin n_mis++; $display("FAIL busy_status: got %h expected %h", v, 32'hA000_0000); end
        rd(12'h803, v);
        if (SD_start === 1'b1) early++;
        n_cmp++; if (v !== 32'h8000_00AB) begin n_mis++; $display("FAIL busy_pending_rb: got %h expected %h", v, 32'h8000_00AB); end
        step();
        n_cmp++; if (early !== 0) begin n_mis++; $display("FAIL busy_no_early_start: got %0d pulses expected 0", early); end
        SD_busy = 1'b0;
        #1;
        n_cmp++; if (SD_start !== 1'b1) begin n_mis++; $display("FAIL busy_release_start: got %b expected 1", SD_start); end
        step();
        n_cmp++; if (SD_start !== 1'b0) begin n_mis++; $display("FAIL busy_single_pulse: got %b expected 0", SD_start); end
        wr(12'h806, 32'h2000_0000);
        peek(12'h806, v);
        n_cmp++; if (v !== 32'h0) begin n_mis++; $display("FAIL err_clear: got %h expected 0", v); end
    endtask

    task automatic test_uart();
        logic [31:0] v;
        wr(12'h804, 32'h0000_0ABC);
        n_cmp++; if (UART_setAddr !== 1'b1 || UART_addr !== 12'hABC) begin n_mis++; $display("FAIL uart_strobe: got %b/%h expected 1/abc", UART_setAddr, UART_addr); end
        step();
        n_cmp++; if (UART_setAddr !== 1'b0) begin n_mis++; $display("FAIL uart_strobe_len: got %b expected 0", UART_setAddr); end
        UART_lastByte = 8'h5A;
        rd(12'h804, v);
        n_cmp++; if (v !== 32'h0000_005A) begin n_mis++; $display("FAIL uart_read: got %h expected %h", v, 32'h5A); end
    endtask

    task automatic test_fifo();
        logic [31:0] v;
        logic [31:0] exp_w;
        logic        exp_ovf;
        exp_ovf = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            SD_response = 8'(b);
            SD_responseByte = 1'b1;
            if (sb_q.size() < 4) sb_q.push_back({1'b1, 23'b0, 8'(b)});
            else exp_ovf = 1'b1;
            step();
        end
        SD_responseByte = 1'b0;
        exp_w = {1'b0, exp_ovf, 1'b0, 21'b0, 8'(sb_q.size())};
        peek(12'h806, v);
        n_cmp++; if (v !== exp_w) begin n_mis++; $display("FAIL fifo_status_full: got %h expected %h", v, exp_w); end
        while (sb_q.size() > 0) begin
            exp_w = sb_q.pop_front();
            rd(12'h805, v);
            n_cmp++; if (v !== exp_w) begin n_mis++; $display("FAIL fifo_pop: got %h expected %h", v, exp_w); end
        end
        rd(12'h805, v);
        n_cmp++; if (v !== 32'h0000_00FF) begin n_mis++; $display("FAIL fifo_empty_read: got %h expected %h", v, 32'hFF); end
        wr(12'h806, 32'h4000_0000);
        peek(12'h806, v);
        n_cmp++; if (v !== 32'h0) begin n_mis++; $display("FAIL ovf_clear: got %h expected 0", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [31:0] exp_w;
        for (int b = 0; b < 4; b++) begin
            SD_response = 8'hA0 + 8'(b);
            SD_responseByte = 1'b1;
            sb_q.push_back({1'b1, 23'b0, 8'hA0 + 8'(b)});
            step();
        end
        // Push into a full FIFO in the same cycle as a pop.
        SD_response = 8'hA4;
        exp_w = sb_q.pop_front();
        sb_q.push_back({1'b1, 23'b0, 8'hA4});
        rd(12'h805, v);
        SD_responseByte = 1'b0;
        n_cmp++; if (v !== exp_w) begin n_mis++; $display("FAIL b2b_pop: got %h expected %h", v, exp_w); end
        exp_w = {3'b000, 21'b0, 8'(sb_q.size())};
        peek(12'h806, v);
        n_cmp++; if (v !== exp_w) begin n_mis++; $display("FAIL b2b_status: got %h expected %h", v, exp_w); end
        while (sb_q.size() > 0) begin
            exp_w = sb_q.pop_front();
            rd(12'h805, v);
            n_cmp++; if (v !== exp_w) begin n_mis++; $display("FAIL b2b_drain: got %h expected %h", v, exp_w); end
        end
        peek(12'h806, v);
        n_cmp++; if (v !== 32'h0) begin n_mis++; $display("FAIL b2b_empty_status: got %h expected 0", v); end
    endtask

    task automatic test_btn();
        logic [31:0] v;
        BTN = 5'b00100;
        repeat (3) step();
        peek(12'h801, v);
        n_cmp++; if (v !== 32'h4) begin n_mis++; $display("FAIL btn_edge_set: got %h expected %h", v, 32'h4); end
        peek(12'h800, v);
        n_cmp++; if (v !== 32'h4) begin n_mis++; $display("FAIL btn_live: got %h expected %h", v, 32'h4); end
        BTN = 5'b00101;
        repeat (2) step();
        // Bit 0 edge is now live in the synchroniser for this read cycle.
        rd(12'h801, v);
        n_cmp++; if (v !== 32'h4) begin n_mis++; $display("FAIL btn_read_val: got %h expected %h", v, 32'h4); end
        peek(12'h801, v);
        n_cmp++; if (v !== 32'h1) begin n_mis++; $display("FAIL btn_clear_edge_wins: got %h expected %h", v, 32'h1); end
        rd(12'h801, v);
        peek(12'h801, v);
        n_cmp++; if (v !== 32'h0) begin n_mis++; $display("FAIL btn_cleared: got %h expected 0", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(12'h802, 32'h5555_AAAA);
        addr = 12'h803; dataIn = 32'h8000_0011; writeEnable = 1'b1;
        step();
        writeEnable = 1'b0;
        SD_busy = 1'b1;
        #1;
        reset = 1'b1;
        SD_busy = 1'b0;
        #1;
        n_cmp++; if (SD_start !== 1'b0) begin n_mis++; $display("FAIL rst_mid_no_pulse: got %b expected 0", SD_start); end
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (SD_start !== 1'b0 || SD_cmd !== 48'h0) begin n_mis++; $display("FAIL rst_mid_after: got %b/%h expected 0/0", SD_start, SD_cmd); end
        peek(12'h806, v);
        n_cmp++; if (v !== 32'h0) begin n_mis++; $display("FAIL rst_mid_status: got %h expected 0", v); end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        addr = '0;
        dataIn = '0;
        writeEnable = 1'b0;
        readEnable = 1'b0;
        RAM_out = '0;
        BTN = '0;
        SD_responseByte = 1'b0;
        SD_response = '0;
        SD_busy = 1'b0;
        UART_lastByte = '0;
        test_reset();
        test_ram();
        test_sd_start();
        test_busy();
        test_uart();
        test_fifo();
        test_back_to_back();
        test_btn();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
